pc_sequencer: RTL

- Program-counter controller for the single-cycle core. Owns the PC register and computes the sequential and branch-target addresses.
- Selects next-PC from sequential, conditional branch, jump/call and return sources.
- Holds a small return-address stack (RAS) and a boot/run/halt state machine.
- Feeds instruction-memory address and tells downstream when the fetched instruction is valid.

---
 rtl/pc_seq_pkg.sv | 6 +
 rtl/pc_sequencer_ras.sv | 35 +++
 rtl/pc_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state and next-pc source encodings for the pc sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  localparam int PC_INC = 4;
  typedef enum logic [2:0] {SEQ, BR, JMP, RET, HOLD} pc_sel_t;
endpackage

// File: rtl/pc_sequencer_ras.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int WL = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [WL-1:0] din,
  output logic [WL-1:0] top,
  output logic          empty,
  output logic          full
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [WL-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (pop) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
  assign top   = mem[ptr - 1'b1];
  assign empty = cnt == '0;
  assign full  = cnt == (PW+1)'(RAS_DEPTH);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: pc register, next-pc selection, return-address stack and boot/run/halt control
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int            WL = 32,
  parameter logic [WL-1:0] RESET_VEC = '0,
  parameter int            RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          branch,
  input  logic          zero,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic [WL-1:0] simm,
  input  logic [WL-1:0] jaddr,
  output logic [WL-1:0] pc,
  output logic [WL-1:0] pc_plus4,
  output logic [WL-1:0] pc_branch,
  output logic          instr_valid,
  output logic          halted,
  output logic          ras_overflow,
  output logic          ras_underflow
);
  state_t        state, nstate;
  pc_sel_t       sel;
  logic [WL-1:0] npc, ras_top;
  logic          push, pop, empty, full, set_ov, set_un;
  ras_stack #(.WL(WL), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(pc_plus4),
    .top(ras_top), .empty(empty), .full(full)
  );
  assign pc_plus4    = pc + WL'(PC_INC);
  assign pc_branch   = pc_plus4 + (simm << 2);
  assign instr_valid = state == RUN;
  assign halted      = state == HALT;
  always_comb begin
    nstate = state;
    sel    = HOLD;
    push   = 1'b0;
    pop    = 1'b0;
    set_ov = 1'b0;
    set_un = 1'b0;
    if (state == BOOT) nstate = RUN;
    else if (state == RUN) begin
      if (halt) nstate = HALT;
      else if (stall) sel = HOLD;
      else if (ret) begin
        pop    = !empty;
        set_un = empty;
        sel    = empty ? SEQ : RET;
      end else if (call) begin
        push   = 1'b1;
        set_ov = full;
        sel    = JMP;
      end else if (jump) sel = JMP;
      else if (branch && zero) sel = BR;
      else sel = SEQ;
    end
    npc = sel == SEQ ? pc_plus4 :
          sel == BR  ? pc_branch :
          sel == JMP ? (jaddr & ~WL'(3)) :
          sel == RET ? ras_top : pc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_VEC;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state         <= nstate;
      pc            <= npc;
      ras_overflow  <= ras_overflow | set_ov;
      ras_underflow <= ras_underflow | set_un;
    end
endmodule
